// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hazard_ctrl_if : pipeline-side signals of the hazard controller            |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
interface hazard_ctrl_if #(
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
);
    logic [ADDR_W-1:0] rs1_id;
    logic [ADDR_W-1:0] rs2_id;
    logic              rs1_used_id;
    logic              rs2_used_id;
    logic [ADDR_W-1:0] rd_ex;
    logic              memread_ex;
    logic              regwrite_ex;
    logic [ADDR_W-1:0] rd_mem;
    logic              regwrite_mem;
    logic              branch_taken_ex;
    logic              dmem_wait;
    logic              pc_en;
    logic              ifid_en;
    logic              idex_en;
    logic              exmem_en;
    logic              ifid_flush;
    logic              idex_flush;
    logic              memwb_flush;
    logic              hazard_stall;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output rs1_id, rs2_id, rs1_used_id, rs2_used_id, rd_ex, memread_ex,
               regwrite_ex, rd_mem, regwrite_mem, branch_taken_ex, dmem_wait,
        input  pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush,
               memwb_flush, hazard_stall, stall_cnt
    );

    modport slave (
        input  rs1_id, rs2_id, rs1_used_id, rs2_used_id, rd_ex, memread_ex,
               regwrite_ex, rd_mem, regwrite_mem, branch_taken_ex, dmem_wait,
        output pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush,
               memwb_flush, hazard_stall, stall_cnt
    );
endinterface
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hazard_ctrl : RAW/load-use stall, branch flush and dmem freeze control     |
// | Optional macro HAZARD_FWD_EN: EX/MEM forwarding present, only loads stall  |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module hazard_ctrl #(
    parameter int ADDR_W    = 5,
    parameter int LU_CYCLES = 1,
    parameter int CNT_W     = 16
) (
    input wire           clk,
    input wire           rst,
    hazard_ctrl_if.slave hz
);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } state_t;

    // RUN already spends one bubble, so the counter covers the remaining ones minus one
    localparam logic [2:0] c_LU_LOAD = (LU_CYCLES > 1) ? 3'(LU_CYCLES - 2) : 3'd0;

    state_t           r_state;
    logic [2:0]       r_cnt;
    logic [CNT_W-1:0] r_stall_cnt;

    logic w_rs1_ex, w_rs2_ex, w_lu_hit, w_raw, w_stall;
    logic w_pc_en, w_ifid_en, w_idex_en, w_exmem_en;
    logic w_ifid_flush, w_idex_flush, w_memwb_flush, w_hazard_stall;

    assign w_rs1_ex = hz.rs1_used_id && (hz.rs1_id == hz.rd_ex) && (hz.rd_ex != '0);
    assign w_rs2_ex = hz.rs2_used_id && (hz.rs2_id == hz.rd_ex) && (hz.rd_ex != '0);
    assign w_lu_hit = hz.memread_ex && hz.regwrite_ex && (w_rs1_ex || w_rs2_ex);

`ifdef HAZARD_FWD_EN
    assign w_raw = 1'b0;
`else
    logic w_rs1_mem, w_rs2_mem;
    assign w_rs1_mem = hz.rs1_used_id && (hz.rs1_id == hz.rd_mem) && (hz.rd_mem != '0);
    assign w_rs2_mem = hz.rs2_used_id && (hz.rs2_id == hz.rd_mem) && (hz.rd_mem != '0);
    assign w_raw = (hz.regwrite_ex && (w_rs1_ex || w_rs2_ex)) ||
                   (hz.regwrite_mem && (w_rs1_mem || w_rs2_mem));
`endif

    assign w_stall = (r_state == ST_STALL) || w_lu_hit || w_raw;

    // Priority: reset, memory wait, taken branch, stall, free-running
    always_comb begin
        w_pc_en        = 1'b1;
        w_ifid_en      = 1'b1;
        w_idex_en      = 1'b1;
        w_exmem_en     = 1'b1;
        w_ifid_flush   = 1'b0;
        w_idex_flush   = 1'b0;
        w_memwb_flush  = 1'b0;
        w_hazard_stall = 1'b0;
        if (rst) begin
            w_pc_en       = 1'b0;
            w_ifid_en     = 1'b0;
            w_idex_en     = 1'b0;
            w_exmem_en    = 1'b0;
            w_ifid_flush  = 1'b1;
            w_idex_flush  = 1'b1;
            w_memwb_flush = 1'b1;
        end else if (hz.dmem_wait) begin
            w_pc_en        = 1'b0;
            w_ifid_en      = 1'b0;
            w_idex_en      = 1'b0;
            w_exmem_en     = 1'b0;
            w_memwb_flush  = 1'b1;
            w_hazard_stall = w_stall;
        end else if (hz.branch_taken_ex) begin
            w_ifid_flush = 1'b1;
            w_idex_flush = 1'b1;
        end else if (w_stall) begin
            w_pc_en        = 1'b0;
            w_ifid_en      = 1'b0;
            w_idex_flush   = 1'b1;
            w_hazard_stall = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_RUN;
            r_cnt       <= 3'd0;
            r_stall_cnt <= '0;
        end else begin
            if (!w_pc_en && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (!hz.dmem_wait) begin
                if (hz.branch_taken_ex) begin
                    r_state <= ST_RUN;
                    r_cnt   <= 3'd0;
                end else if (r_state == ST_STALL) begin
                    if (r_cnt == 3'd0) begin
                        r_state <= ST_RUN;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end else if (w_lu_hit && (LU_CYCLES > 1)) begin
                    r_state <= ST_STALL;
                    r_cnt   <= c_LU_LOAD;
                end
            end
        end
    end

    assign hz.pc_en        = w_pc_en;
    assign hz.ifid_en      = w_ifid_en;
    assign hz.idex_en      = w_idex_en;
    assign hz.exmem_en     = w_exmem_en;
    assign hz.ifid_flush   = w_ifid_flush;
    assign hz.idex_flush   = w_idex_flush;
    assign hz.memwb_flush  = w_memwb_flush;
    assign hz.hazard_stall = w_hazard_stall;
    assign hz.stall_cnt    = r_stall_cnt;

endmodule
`default_nettype wire
